fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage RV32 pipeline, directly upstream of decode1.
//   Holds the PC, issues single-outstanding requests to instruction memory and
//   presents instr_reg_fetch/pc_fetch/npc_fetch on the IF/ID register.
//   Handles decode back-pressure (stall) and EX-stage redirects (branch/jump).
// PARAMETERS
//   data_width  32            instruction/address width
//   RESET_PC    32'h0000_0000 PC loaded on reset
//   NOP_INSTR   32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//   clk              in   1           clock, all state on rising edge
//   rst              in   1           synchronous, active-high reset
//   stall_decode     in   1           decode cannot accept; hold IF/ID outputs
//   redirect_valid   in   1           EX redirect; priority over stall
//   redirect_pc      in   data_width  redirect target
//   imem_req         out  1           one-cycle request pulse
//   imem_addr        out  data_width  request address (= pc_reg)
//   imem_rdata       in   data_width  instruction word
//   imem_rvalid      in   1           rdata valid, >=1 cycle after imem_req
//   instr_reg_fetch  out  data_width  IF/ID instruction
//   pc_fetch         out  data_width  IF/ID PC
//   npc_fetch        out  data_width  IF/ID PC+4
//   fetch_valid      out  1           IF/ID holds a real instruction
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is synchronous and active-high.
//   Reset: pc_reg=RESET_PC, state=ISSUE, instr_reg_fetch=NOP_INSTR,
//     pc_fetch=0, npc_fetch=0, fetch_valid=0, skid buffer empty; imem_req=0
//     while rst=1.
//   FSM states: ISSUE, WAIT, HOLD, DRAIN.
//   ISSUE: imem_req = ~redirect_valid, imem_addr=pc_reg; -> WAIT on req.
//     imem_rvalid ignored in ISSUE.
//   WAIT: on imem_rvalid:
//     IF/ID free (fetch_valid=0 or stall_decode=0): load instr=rdata,
//       pc_fetch=pc_reg, npc_fetch=pc_reg+4, fetch_valid=1; pc_reg+=4; -> ISSUE.
//     else: capture rdata in skid buffer; -> HOLD.
//   HOLD: no request; when stall_decode=0 load IF/ID from skid, pc_reg+=4, -> ISSUE.
//   IF/ID consumed (stall_decode=0) with no new word: fetch_valid<=0,
//     instr_reg_fetch<=NOP_INSTR; pc/npc hold.
//   stall_decode=1 with fetch_valid=1: all IF/ID outputs hold exactly.
//   Redirect (any state, overrides stall): pc_reg<={redirect_pc[31:2],2'b00};
//     fetch_valid<=0, instr<=NOP_INSTR; skid discarded.
//     WAIT without rvalid -> DRAIN; WAIT with rvalid -> data dropped, -> ISSUE;
//     ISSUE/HOLD -> ISSUE. Fetch latency after redirect >= 2 cycles.
//   DRAIN: no request; discard next rvalid, -> ISSUE. New redirect in DRAIN
//     updates pc_reg, stays DRAIN (or -> ISSUE if rvalid same cycle).
//   Arithmetic: pc+4 modulo 2^data_width (0xFFFFFFFC -> 0x00000000).
//   Throughput: max one instruction per 2 cycles (ISSUE+WAIT).
//   Reset mid-operation: state->ISSUE; late rvalid ignored (imem shares rst).
// TESTING
//   rst=1 2 cycles -> imem_req=0, fetch_valid=0, instr=0x00000013; cycle after
//     release imem_req=1, imem_addr=0x0.
//   rvalid 1 cycle after req, rdata=0x00500093 -> instr=0x00500093, pc_fetch=0,
//     npc_fetch=4, fetch_valid=1; next req addr=0x4.
//   stall_decode=1 while rvalid for addr 4 -> outputs frozen at addr-0 word, no
//     req; drop stall -> pc_fetch=4 next cycle, then req addr=0x8.
//   redirect_valid=1, redirect_pc=0x100 in WAIT -> fetch_valid=0 next cycle, next
//     rvalid discarded, next req addr=0x100.
//   redirect_pc=0xFFFFFFFC, response 0x00000013 -> npc_fetch=0x0, next req addr=0x0.
//   redirect_pc=0x103 -> imem_addr=0x100; redirect+stall same cycle -> redirect wins.

Source files
------------

// File: rtl/fetch_stage_if.sv
// IF-stage bus bundle: decode control, redirect, instruction-memory port and IF/ID register.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if #(
  parameter int DW = 32
);
  logic          stall_decode;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_rvalid;
  logic [DW-1:0] instr_reg_fetch;
  logic [DW-1:0] pc_fetch;
  logic [DW-1:0] npc_fetch;
  logic          fetch_valid;

  modport master (
    input  stall_decode, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
    output imem_req, imem_addr, instr_reg_fetch, pc_fetch, npc_fetch, fetch_valid
  );

  modport slave (
    output stall_decode, redirect_valid, redirect_pc, imem_rdata, imem_rvalid,
    input  imem_req, imem_addr, instr_reg_fetch, pc_fetch, npc_fetch, fetch_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32 IF stage: single-outstanding imem fetch into the IF/ID register, 2-cycle issue-to-result.
// Decode stall freezes IF/ID and parks a returning word in a skid register; EX redirect beats stall.
module fetch_stage #(
  parameter int                    data_width = 32,
  parameter logic [data_width-1:0] RESET_PC   = '0,
  parameter logic [data_width-1:0] NOP_INSTR  = data_width'(32'h0000_0013)
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [data_width-1:0] r_pc;
  logic [data_width-1:0] r_skid;
  logic [data_width-1:0] r_instr;
  logic [data_width-1:0] r_pc_fetch;
  logic [data_width-1:0] r_npc_fetch;
  logic                  r_fetch_valid;

  logic [data_width-1:0] w_redirect_aligned;
  logic [data_width-1:0] w_pc_plus4;
  logic                  w_ifid_free;
  logic                  w_consume;
  logic                  w_req;

  assign w_redirect_aligned = bus.redirect_pc & ~data_width'(3);
  assign w_pc_plus4         = r_pc + data_width'(4);
  assign w_ifid_free        = ~r_fetch_valid | ~bus.stall_decode;
  assign w_consume          = r_fetch_valid & ~bus.stall_decode;
  assign w_req              = (r_state == S_ISSUE) & ~bus.redirect_valid & ~rst;

  assign bus.imem_req        = w_req;
  assign bus.imem_addr       = r_pc;
  assign bus.instr_reg_fetch = r_instr;
  assign bus.pc_fetch        = r_pc_fetch;
  assign bus.npc_fetch       = r_npc_fetch;
  assign bus.fetch_valid     = r_fetch_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ISSUE;
      r_pc          <= RESET_PC;
      r_skid        <= '0;
      r_instr       <= NOP_INSTR;
      r_pc_fetch    <= '0;
      r_npc_fetch   <= '0;
      r_fetch_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc          <= w_redirect_aligned;
      r_fetch_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      // An in-flight response must be swallowed before the new target is requested.
      case (r_state)
        S_WAIT, S_DRAIN: r_state <= bus.imem_rvalid ? S_ISSUE : S_DRAIN;
        default:         r_state <= S_ISSUE;
      endcase
    end else begin
      if (w_consume) begin
        r_fetch_valid <= 1'b0;
        r_instr       <= NOP_INSTR;
      end
      case (r_state)
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (w_ifid_free) begin
              r_instr       <= bus.imem_rdata;
              r_pc_fetch    <= r_pc;
              r_npc_fetch   <= w_pc_plus4;
              r_fetch_valid <= 1'b1;
              r_pc          <= w_pc_plus4;
              r_state       <= S_ISSUE;
            end else begin
              r_skid  <= bus.imem_rdata;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.stall_decode) begin
            r_instr       <= r_skid;
            r_pc_fetch    <= r_pc;
            r_npc_fetch   <= w_pc_plus4;
            r_fetch_valid <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_state       <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) r_state <= S_ISSUE;
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

endmodule
